// File: rtl/pdm_mic_capture.sv
// PDM microphone front end: generates mic_clk, counts ones per 2**dec_log2-bit window,
// and pushes one PCM sample per window into a FIFO, with warm-up discard and overflow flag.
module pdm_mic_capture #(
  parameter int dat_width = 8,
  parameter int dec_log2  = 8,
  parameter int clk_div   = 32,
  parameter int warmup    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 pdm_data,
  input  logic                 full,
  output logic                 mic_clk,
  output logic                 wr,
  output logic [dat_width-1:0] data_out,
  output logic                 busy,
  output logic                 overflow
);

  localparam int DIV_W  = $clog2(clk_div);
  localparam int WARM_W = (warmup < 2) ? 1 : $clog2(warmup + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(clk_div - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(clk_div / 2);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic [dec_log2-1:0]    bit_cnt_q, bit_cnt_d;
  logic [dec_log2:0]      ones_cnt_q, ones_cnt_d;
  logic [WARM_W-1:0]      warm_cnt_q, warm_cnt_d;
  logic                   sync1_q, sync2_q;
  logic                   mic_clk_q, mic_clk_d;
  logic                   pend_q, pend_d;
  logic [dat_width-1:0]   samp_q, samp_d;
  logic [dat_width-1:0]   last_q, last_d;
  logic                   ovf_q, ovf_d;

  logic                   active;
  logic                   bit_tick;
  logic                   win_end;
  logic [dec_log2:0]      ones_next;

  // A full window of ones overflows by one count; clamp it into dec_log2 bits.
  function automatic logic [dec_log2-1:0] sat_window(input logic [dec_log2:0] v);
    return v[dec_log2] ? {dec_log2{1'b1}} : v[dec_log2-1:0];
  endfunction

  function automatic logic [dat_width-1:0] to_pcm(input logic [dec_log2-1:0] s);
    return dat_width'(s >> (dec_log2 - dat_width));
  endfunction

  assign active    = (state_q != IDLE);
  assign bit_tick  = active && (div_cnt_q == DIV_LAST);
  assign win_end   = bit_tick && (bit_cnt_q == {dec_log2{1'b1}});
  assign ones_next = ones_cnt_q + {{dec_log2{1'b0}}, sync2_q};

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    ones_cnt_d = ones_cnt_q;
    warm_cnt_d = warm_cnt_q;
    pend_d     = 1'b0;
    samp_d     = samp_q;
    last_d     = last_q;
    ovf_d      = ovf_q;

    // Resolve the write that was scheduled by the previous window end.
    if (pend_q) begin
      if (full) ovf_d  = 1'b1;
      else      last_d = samp_q;
    end

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d    = (warmup == 0) ? RUN : WARMUP;
          warm_cnt_d = WARM_W'(warmup);
          ovf_d      = 1'b0;
        end
      end
      default: begin
        if (!en) begin
          state_d    = IDLE;
          div_cnt_d  = '0;
          bit_cnt_d  = '0;
          ones_cnt_d = '0;
          warm_cnt_d = '0;
        end else begin
          div_cnt_d = bit_tick ? '0 : div_cnt_q + 1'b1;
          if (bit_tick) begin
            bit_cnt_d  = bit_cnt_q + 1'b1;
            ones_cnt_d = win_end ? '0 : ones_next;
          end
          if (win_end) begin
            if (state_q == RUN) begin
              pend_d = 1'b1;
              samp_d = to_pcm(sat_window(ones_next));
            end else begin
              warm_cnt_d = warm_cnt_q - 1'b1;
              if (warm_cnt_q == WARM_W'(1)) state_d = RUN;
            end
          end
        end
      end
    endcase

    mic_clk_d = (state_d != IDLE) && (div_cnt_d < DIV_HALF);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      ones_cnt_q <= '0;
      warm_cnt_q <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      mic_clk_q  <= 1'b0;
      pend_q     <= 1'b0;
      samp_q     <= '0;
      last_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      warm_cnt_q <= warm_cnt_d;
      sync1_q    <= pdm_data;
      sync2_q    <= sync1_q;
      mic_clk_q  <= mic_clk_d;
      pend_q     <= pend_d;
      samp_q     <= samp_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
    end
  end

  // wr is gated by the live full flag so it can never coincide with full=1.
  assign wr       = pend_q && !full;
  assign data_out = wr ? samp_q : last_q;
  assign mic_clk  = mic_clk_q;
  assign busy     = active;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Bench for pdm_mic_capture: small windows, behavioural window-sum model checked every cycle,
// plus literal expectations for constant, alternating, full, stop and reset scenarios.
module tb_pdm_mic_capture;

  localparam int W    = 4;
  localparam int DEC  = 5;
  localparam int DIV  = 4;
  localparam int WARM = 2;
  localparam int WIN  = 1 << DEC;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         pdm;
  logic         full;
  logic         mic_clk;
  logic         wr;
  logic [W-1:0] data_out;
  logic         busy;
  logic         overflow;

  int tests = 0;
  int fails = 0;

  pdm_mic_capture #(.dat_width(W), .dec_log2(DEC), .clk_div(DIV), .warmup(WARM)) dut (
    .clk(clk), .reset(reset), .en(en), .pdm_data(pdm), .full(full),
    .mic_clk(mic_clk), .wr(wr), .data_out(data_out), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails < 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a busy-cycle counter, a queue of sampled bits per window.
  bit m_busy, m_pend, m_ovf, m_p1, m_p2, m_b;
  int m_t, m_warm, m_samp, m_last, m_ones;
  bit win_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_pend = 0; m_ovf = 0; m_p1 = 0; m_p2 = 0;
      m_t = 0; m_warm = 0; m_samp = 0; m_last = 0;
      win_q.delete();
    end else begin
      m_b = m_p2; m_p2 = m_p1; m_p1 = pdm;
      if (m_pend) begin
        if (full) m_ovf = 1;
        else      m_last = m_samp;
        m_pend = 0;
      end
      if (!m_busy) begin
        if (en) begin
          m_busy = 1; m_t = 0; m_warm = WARM; m_ovf = 0;
          win_q.delete();
        end
      end else if (!en) begin
        m_busy = 0;
      end else begin
        if (m_t % DIV == DIV - 1) begin
          win_q.push_back(m_b);
          if (win_q.size() == WIN) begin
            m_ones = 0;
            foreach (win_q[k]) m_ones += win_q[k];
            if (m_ones > WIN - 1) m_ones = WIN - 1;
            if (m_warm > 0) m_warm--;
            else begin
              m_pend = 1;
              m_samp = m_ones >> (DEC - W);
            end
            win_q.delete();
          end
        end
        m_t++;
      end
    end
  end

  bit exp_wr;
  always @(negedge clk) begin
    if (!reset) begin
      exp_wr = m_pend && !full;
      chk("busy", busy, m_busy);
      chk("mic_clk", mic_clk, m_busy && ((m_t % DIV) < DIV / 2));
      chk("wr", wr, exp_wr);
      chk("data_out", data_out, exp_wr ? m_samp : m_last);
      chk("overflow", overflow, m_ovf);
    end
  end

  int wr_cnt = 0;
  int last_wr = -1;
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      wr_cnt++;
      last_wr = data_out;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Enable, run 645 cycles (two warm-up windows then three written windows), stop.
  task automatic run_phase(input int mode, input int exp_val);
    wr_cnt = 0;
    pdm = (mode == 1);
    en = 1;
    for (int i = 0; i < 645; i++) begin
      cyc();
      if (mode == 2 && i % DIV == 0) pdm = ~pdm;
      if (i == 380) chk("warmup_no_wr", wr_cnt, 0);
    end
    chk("phase_writes", wr_cnt, 3);
    chk("phase_data", last_wr, exp_val);
    en = 0;
    repeat (4) cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; en = 0; pdm = 0; full = 0;
    #12;
    chk("rst_mic_clk", mic_clk, 0);
    chk("rst_wr", wr, 0);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    @(posedge clk); #1 reset = 0;
    repeat (3) cyc();
    chk("idle_busy", busy, 0);

    run_phase(1, 15);
    run_phase(0, 0);
    run_phase(2, 8);

    // Full held across the first RUN window end.
    wr_cnt = 0; pdm = 1; en = 1;
    for (int i = 0; i < 645; i++) begin
      cyc();
      full = (i >= 300 && i < 420);
    end
    chk("full_writes", wr_cnt, 2);
    chk("full_data", last_wr, 15);
    chk("full_ovf", overflow, 1);
    en = 0;
    repeat (4) cyc();
    chk("ovf_sticky_idle", overflow, 1);
    en = 1;
    repeat (2) cyc();
    chk("ovf_cleared_start", overflow, 0);
    en = 0;
    repeat (4) cyc();

    // Stop partway into the first RUN window, then restart fresh.
    pdm = 0; en = 1; wr_cnt = 0;
    repeat (340) cyc();
    en = 0;
    cyc();
    chk("stop_busy", busy, 0);
    chk("stop_mic_clk", mic_clk, 0);
    chk("stop_no_wr", wr_cnt, 0);
    repeat (3) cyc();
    run_phase(1, 15);

    // Asynchronous reset while running.
    pdm = 1; en = 1;
    repeat (400) cyc();
    @(posedge clk);
    #3 reset = 1;
    #1;
    chk("arst_wr", wr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_mic_clk", mic_clk, 0);
    chk("arst_data", data_out, 0);
    chk("arst_ovf", overflow, 0);
    en = 0;
    @(posedge clk); #1 reset = 0;
    repeat (3) cyc();
    chk("post_rst_idle", busy, 0);
    run_phase(2, 8);

    // Random bits with random back-pressure.
    en = 1;
    for (int i = 0; i < 1500; i++) begin
      cyc();
      pdm  = $urandom_range(0, 1);
      full = ($urandom_range(0, 3) == 0);
    end
    en = 0; full = 0;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
